// File: rtl/ex_muldiv_stage_pkg.sv
// Shared definitions for the EX stage: ALU opcodes, mul/div FSM states and sizing.
// Define EX_MULDIV_DIV_EN to route DIV/DIVU through the iterative divider.
package ex_pkg;

    localparam int CTRL_W     = 16;
    localparam int ITER_COUNT = 32;
    localparam int CNT_W      = $clog2(ITER_COUNT);

    typedef enum logic [3:0] {
        OP_ADD   = 4'd0,
        OP_SUB   = 4'd1,
        OP_AND   = 4'd2,
        OP_OR    = 4'd3,
        OP_XOR   = 4'd4,
        OP_NOR   = 4'd5,
        OP_SLT   = 4'd6,
        OP_SLTU  = 4'd7,
        OP_SLL   = 4'd8,
        OP_SRL   = 4'd9,
        OP_SRA   = 4'd10,
        OP_MULT  = 4'd11,
        OP_MULTU = 4'd12,
        OP_DIV   = 4'd13,
        OP_DIVU  = 4'd14
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Ops that take the multi-cycle path and therefore stall the front end.
    function automatic logic is_muldiv(input logic [3:0] op);
`ifdef EX_MULDIV_DIV_EN
        return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
`else
        return (op == OP_MULT) || (op == OP_MULTU);
`endif
    endfunction

endpackage

// File: rtl/ex_muldiv_stage_if.sv
// ID/EX -> EX/MEM signal bundle for the EX stage; the stage uses the slave modport.
interface ex_muldiv_stage_if;
    import ex_pkg::*;

    logic              iValid;
    logic [3:0]        iOp;
    logic [31:0]       iReadReg1;
    logic [31:0]       iReadReg2;
    logic [31:0]       iImm;
    logic [31:0]       iPCPlus4;
    logic [4:0]        iRegDst;
    logic [CTRL_W-1:0] iCtrl;
    logic              iFlush;
    logic              oStall;
    logic              oValid;
    logic [CTRL_W-1:0] oCtrl;
    logic              oZero;
    logic [31:0]       oALUResult;
    logic [63:0]       oHiLoResult;
    logic [31:0]       oPCSumImm;
    logic [31:0]       oPCPlus4;
    logic [31:0]       oReadReg1;
    logic [31:0]       oReadReg2;
    logic [4:0]        oRegDstResult;

    modport slave (
        input  iValid, iOp, iReadReg1, iReadReg2, iImm, iPCPlus4, iRegDst, iCtrl, iFlush,
        output oStall, oValid, oCtrl, oZero, oALUResult, oHiLoResult, oPCSumImm,
               oPCPlus4, oReadReg1, oReadReg2, oRegDstResult
    );

    modport master (
        output iValid, iOp, iReadReg1, iReadReg2, iImm, iPCPlus4, iRegDst, iCtrl, iFlush,
        input  oStall, oValid, oCtrl, oZero, oALUResult, oHiLoResult, oPCSumImm,
               oPCPlus4, oReadReg1, oReadReg2, oRegDstResult
    );
endinterface

// File: rtl/ex_muldiv_unit.sv
// Iterative 32-step multiplier (and divider when EX_MULDIV_DIV_EN is defined) working on
// operand magnitudes with a sign fix-up on the way out; start loads, done flags the last step.
module ex_muldiv_unit
    import ex_pkg::*;
(
    input  logic        Clk,
    input  logic        Reset,
    input  logic        start,
    input  logic        kill,
    input  logic [3:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        done,
    output logic [63:0] result
);
    logic             busy_q, busy_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [63:0]      acc_q, acc_d;
    logic [31:0]      mag_q, mag_d;
    logic             neg_lo_q, neg_lo_d;
    logic             is_signed;
    logic [31:0]      abs_a, abs_b;
    logic [32:0]      mul_sum;
    logic [63:0]      mul_step, product;
`ifdef EX_MULDIV_DIV_EN
    logic             is_div_q, is_div_d;
    logic             neg_hi_q, neg_hi_d;
    logic             div0_q, div0_d;
    logic [31:0]      dvd_q, dvd_d;
    logic [32:0]      rem_sh;
    logic             rem_ge;
    logic [63:0]      div_step;
    logic [31:0]      quo, rem;

    assign is_signed = (op == OP_MULT) || (op == OP_DIV);
`else
    assign is_signed = (op == OP_MULT);
`endif

    assign abs_a = (is_signed && a[31]) ? -a : a;
    assign abs_b = (is_signed && b[31]) ? -b : b;

    // Shift-add: multiplier sits in the low half, partial product accumulates in the high half.
    assign mul_sum  = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, mag_q} : 33'd0);
    assign mul_step = {mul_sum, acc_q[31:1]};
    assign product  = neg_lo_q ? -acc_q : acc_q;

`ifdef EX_MULDIV_DIV_EN
    // Restoring division: {remainder, quotient} shifts left, quotient bits enter at bit 0.
    assign rem_sh   = acc_q[63:31];
    assign rem_ge   = rem_sh >= {1'b0, mag_q};
    assign div_step = rem_ge ? {rem_sh[31:0] - mag_q, acc_q[30:0], 1'b1}
                             : {rem_sh[31:0], acc_q[30:0], 1'b0};
    assign quo      = neg_lo_q ? -acc_q[31:0]  : acc_q[31:0];
    assign rem      = neg_hi_q ? -acc_q[63:32] : acc_q[63:32];
    assign result   = !is_div_q ? product : (div0_q ? {dvd_q, 32'hFFFF_FFFF} : {rem, quo});
`else
    assign result   = product;
`endif

    assign done = busy_q && (cnt_q == CNT_W'(ITER_COUNT - 1));

    always_comb begin
        busy_d   = busy_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        mag_d    = mag_q;
        neg_lo_d = neg_lo_q;
`ifdef EX_MULDIV_DIV_EN
        is_div_d = is_div_q;
        neg_hi_d = neg_hi_q;
        div0_d   = div0_q;
        dvd_d    = dvd_q;
`endif
        if (kill) begin
            busy_d = 1'b0;
        end else if (start) begin
            busy_d   = 1'b1;
            cnt_d    = '0;
            neg_lo_d = is_signed && (a[31] ^ b[31]);
            acc_d    = {32'd0, abs_b};
            mag_d    = abs_a;
`ifdef EX_MULDIV_DIV_EN
            is_div_d = (op == OP_DIV) || (op == OP_DIVU);
            neg_hi_d = is_signed && a[31];
            div0_d   = (b == 32'd0);
            dvd_d    = a;
            if (is_div_d) begin
                acc_d = {32'd0, abs_a};
                mag_d = abs_b;
            end
`endif
        end else if (busy_q) begin
            cnt_d  = cnt_q + CNT_W'(1);
            busy_d = !done;
`ifdef EX_MULDIV_DIV_EN
            acc_d  = is_div_q ? div_step : mul_step;
`else
            acc_d  = mul_step;
`endif
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            busy_q   <= 1'b0;
            cnt_q    <= '0;
            acc_q    <= '0;
            mag_q    <= '0;
            neg_lo_q <= 1'b0;
`ifdef EX_MULDIV_DIV_EN
            is_div_q <= 1'b0;
            neg_hi_q <= 1'b0;
            div0_q   <= 1'b0;
            dvd_q    <= '0;
`endif
        end else begin
            busy_q   <= busy_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            mag_q    <= mag_d;
            neg_lo_q <= neg_lo_d;
`ifdef EX_MULDIV_DIV_EN
            is_div_q <= is_div_d;
            neg_hi_q <= neg_hi_d;
            div0_q   <= div0_d;
            dvd_q    <= dvd_d;
`endif
        end
    end
endmodule

// File: rtl/ex_muldiv_stage.sv
// EX pipeline stage: single-cycle ALU plus iterative mul/div with front-end stall and EX/MEM register.
// DIV/DIVU use the iterative divider only when EX_MULDIV_DIV_EN is defined.
module ex_muldiv_stage
    import ex_pkg::*;
(
    input logic              Clk,
    input logic              Reset,
    ex_muldiv_stage_if.slave bus
);
    state_e            state_q, state_d;
    logic              valid_q, valid_d;
    logic [CTRL_W-1:0] ctrl_q, ctrl_d;
    logic              zero_q, zero_d;
    logic [31:0]       alu_q, alu_d;
    logic [63:0]       hilo_q, hilo_d;
    logic [31:0]       pcsum_q, pcsum_d;
    logic [31:0]       pc4_q, pc4_d;
    logic [31:0]       r1_q, r1_d;
    logic [31:0]       r2_q, r2_d;
    logic [4:0]        rd_q, rd_d;

    logic [31:0] alu_res;
    logic        md_start, md_done;
    logic [63:0] md_result;
    logic        emit;
    logic [31:0] res_alu;
    logic [63:0] res_hilo;

    assign md_start = (state_q == ST_IDLE) && bus.iValid && is_muldiv(bus.iOp) && !bus.iFlush;
    assign bus.oStall = !Reset && (md_start || ((state_q == ST_BUSY) && !bus.iFlush));

    ex_muldiv_unit u_muldiv (
        .Clk    (Clk),
        .Reset  (Reset),
        .start  (md_start),
        .kill   (bus.iFlush),
        .op     (bus.iOp),
        .a      (bus.iReadReg1),
        .b      (bus.iReadReg2),
        .done   (md_done),
        .result (md_result)
    );

    always_comb begin
        alu_res = '0;
        case (bus.iOp)
            OP_ADD:  alu_res = bus.iReadReg1 + bus.iReadReg2;
            OP_SUB:  alu_res = bus.iReadReg1 - bus.iReadReg2;
            OP_AND:  alu_res = bus.iReadReg1 & bus.iReadReg2;
            OP_OR:   alu_res = bus.iReadReg1 | bus.iReadReg2;
            OP_XOR:  alu_res = bus.iReadReg1 ^ bus.iReadReg2;
            OP_NOR:  alu_res = ~(bus.iReadReg1 | bus.iReadReg2);
            OP_SLT:  alu_res = {31'd0, $signed(bus.iReadReg1) < $signed(bus.iReadReg2)};
            OP_SLTU: alu_res = {31'd0, bus.iReadReg1 < bus.iReadReg2};
            OP_SLL:  alu_res = bus.iReadReg1 << bus.iReadReg2[4:0];
            OP_SRL:  alu_res = bus.iReadReg1 >> bus.iReadReg2[4:0];
            OP_SRA:  alu_res = $signed(bus.iReadReg1) >>> bus.iReadReg2[4:0];
            default: alu_res = '0;
        endcase
    end

    // Every path that does not emit an instruction loads a bubble.
    always_comb begin
        state_d  = state_q;
        emit     = 1'b0;
        res_alu  = alu_res;
        res_hilo = '0;
        if (bus.iFlush) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.iValid) begin
                        if (is_muldiv(bus.iOp)) state_d = ST_BUSY;
                        else                    emit    = 1'b1;
                    end
                end
                ST_BUSY: begin
                    if (md_done) state_d = ST_DONE;
                end
                ST_DONE: begin
                    state_d  = ST_IDLE;
                    emit     = 1'b1;
                    res_alu  = '0;
                    res_hilo = md_result;
                end
                default: state_d = ST_IDLE;
            endcase
        end

        valid_d = emit;
        ctrl_d  = emit ? bus.iCtrl : '0;
        alu_d   = emit ? res_alu : '0;
        zero_d  = emit && (res_alu == 32'd0);
        hilo_d  = emit ? res_hilo : '0;
        pcsum_d = emit ? bus.iPCPlus4 + (bus.iImm << 2) : '0;
        pc4_d   = emit ? bus.iPCPlus4 : '0;
        r1_d    = emit ? bus.iReadReg1 : '0;
        r2_d    = emit ? bus.iReadReg2 : '0;
        rd_d    = emit ? bus.iRegDst : '0;
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= ST_IDLE;
            valid_q <= 1'b0;
            ctrl_q  <= '0;
            zero_q  <= 1'b0;
            alu_q   <= '0;
            hilo_q  <= '0;
            pcsum_q <= '0;
            pc4_q   <= '0;
            r1_q    <= '0;
            r2_q    <= '0;
            rd_q    <= '0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            ctrl_q  <= ctrl_d;
            zero_q  <= zero_d;
            alu_q   <= alu_d;
            hilo_q  <= hilo_d;
            pcsum_q <= pcsum_d;
            pc4_q   <= pc4_d;
            r1_q    <= r1_d;
            r2_q    <= r2_d;
            rd_q    <= rd_d;
        end
    end

    assign bus.oValid        = valid_q;
    assign bus.oCtrl         = ctrl_q;
    assign bus.oZero         = zero_q;
    assign bus.oALUResult    = alu_q;
    assign bus.oHiLoResult   = hilo_q;
    assign bus.oPCSumImm     = pcsum_q;
    assign bus.oPCPlus4      = pc4_q;
    assign bus.oReadReg1     = r1_q;
    assign bus.oReadReg2     = r2_q;
    assign bus.oRegDstResult = rd_q;
endmodule

// File: tb/tb_ex_muldiv_stage.sv
// Scoreboard bench for ex_muldiv_stage; expectations follow EX_MULDIV_DIV_EN the same way the design does.
module tb_ex_muldiv_stage;
    import ex_pkg::*;

    typedef struct packed {
        logic [3:0]  op;
        logic [31:0] alu;
        logic        zero;
        logic [63:0] hilo;
        logic [31:0] pcsum;
        logic [31:0] pc4;
        logic [31:0] r1;
        logic [31:0] r2;
        logic [4:0]  rd;
        logic [15:0] ctrl;
    } exp_t;

    logic Clk = 1'b0;
    logic Reset;
    int   checks = 0;
    int   failures = 0;
    int   txn = 0;
    exp_t exp_q[$];

    ex_muldiv_stage_if bus();

    ex_muldiv_stage dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    always #5 Clk = ~Clk;

    function automatic bit ref_multi(input logic [3:0] op);
`ifdef EX_MULDIV_DIV_EN
        return op inside {OP_MULT, OP_MULTU, OP_DIV, OP_DIVU};
`else
        return op inside {OP_MULT, OP_MULTU};
`endif
    endfunction

    function automatic exp_t model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                   input logic [31:0] imm, input logic [31:0] pc,
                                   input logic [4:0] rd, input logic [15:0] ctrl);
        exp_t   e;
        longint sa;
        longint sb;
        e  = '0;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            OP_ADD:   e.alu = a + b;
            OP_SUB:   e.alu = a - b;
            OP_AND:   e.alu = a & b;
            OP_OR:    e.alu = a | b;
            OP_XOR:   e.alu = a ^ b;
            OP_NOR:   e.alu = ~(a | b);
            OP_SLT:   e.alu = (sa < sb) ? 32'd1 : 32'd0;
            OP_SLTU:  e.alu = (a < b) ? 32'd1 : 32'd0;
            OP_SLL:   e.alu = a << b[4:0];
            OP_SRL:   e.alu = a >> b[4:0];
            OP_SRA:   e.alu = 32'(sa >>> b[4:0]);
            OP_MULT:  e.hilo = 64'(sa * sb);
            OP_MULTU: e.hilo = {32'd0, a} * {32'd0, b};
`ifdef EX_MULDIV_DIV_EN
            OP_DIV:   e.hilo = (b == 0) ? {a, 32'hFFFF_FFFF} : {32'(sa % sb), 32'(sa / sb)};
            OP_DIVU:  e.hilo = (b == 0) ? {a, 32'hFFFF_FFFF} : {a % b, a / b};
`endif
            default: ;
        endcase
        e.op    = op;
        e.zero  = (e.alu == 32'd0);
        e.pcsum = pc + imm * 32'd4;
        e.pc4   = pc;
        e.r1    = a;
        e.r2    = b;
        e.rd    = rd;
        e.ctrl  = ctrl;
        return e;
    endfunction

    function automatic logic [31:0] rand_word();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return $urandom_range(0, 20);
            default: return $urandom;
        endcase
    endfunction

    // Present one instruction until the stage consumes it (oStall low before an edge).
    task automatic send(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] imm, input logic [31:0] pc,
                        input logic [4:0] rd, input logic [15:0] ctrl);
        int stalls;
        bit done;
        int want;
        bus.iValid = 1'b1; bus.iOp = op; bus.iReadReg1 = a; bus.iReadReg2 = b;
        bus.iImm = imm; bus.iPCPlus4 = pc; bus.iRegDst = rd; bus.iCtrl = ctrl; bus.iFlush = 1'b0;
        stalls = 0;
        done = 1'b0;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge Clk);
            if (bus.oStall) stalls++;
            else            done = 1'b1;
        end
        want = ref_multi(op) ? 33 : 0;
        checks++;
        if (!done) begin
            failures++;
            $display("FAIL send_timeout op=%0d: stall still high after %0d cycles, required release", op, stalls);
        end else if (stalls != want) begin
            failures++;
            $display("FAIL stall_cycles op=%0d: got %0d required %0d", op, stalls, want);
        end
        if (done) exp_q.push_back(model(op, a, b, imm, pc, rd, ctrl));
        @(posedge Clk); #1;
        bus.iValid = 1'b0;
    endtask

    task automatic idle(input int n);
        bus.iValid = 1'b0;
        repeat (n) @(posedge Clk);
        #1;
    endtask

    task automatic check_quiet(input string name);
        checks++;
        if (bus.oStall || bus.oValid || bus.oCtrl != 0 || bus.oZero || bus.oALUResult != 0 ||
            bus.oHiLoResult != 0 || bus.oPCSumImm != 0 || bus.oPCPlus4 != 0 ||
            bus.oReadReg1 != 0 || bus.oReadReg2 != 0 || bus.oRegDstResult != 0) begin
            failures++;
            $display("FAIL %s: got stall=%b valid=%b ctrl=%h zero=%b alu=%h hilo=%h pcsum=%h pc4=%h r1=%h r2=%h rd=%h, required all 0",
                     name, bus.oStall, bus.oValid, bus.oCtrl, bus.oZero, bus.oALUResult, bus.oHiLoResult,
                     bus.oPCSumImm, bus.oPCPlus4, bus.oReadReg1, bus.oReadReg2, bus.oRegDstResult);
        end
    endtask

    // Monitor: pops the scoreboard on every valid output, checks bubbles otherwise.
    initial begin
        exp_t e;
        exp_t act;
        forever begin
            @(negedge Clk);
            if (bus.oValid) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_valid: got oValid=1 alu=%h hilo=%h, required no output", bus.oALUResult, bus.oHiLoResult);
                end else begin
                    e = exp_q.pop_front();
                    act = '{op: e.op, alu: bus.oALUResult, zero: bus.oZero, hilo: bus.oHiLoResult,
                            pcsum: bus.oPCSumImm, pc4: bus.oPCPlus4, r1: bus.oReadReg1, r2: bus.oReadReg2,
                            rd: bus.oRegDstResult, ctrl: bus.oCtrl};
                    txn++;
                    if (act != e) begin
                        failures++;
                        $display("FAIL txn %0d op=%0d: got alu=%h zero=%b hilo=%h pcsum=%h pc4=%h r1=%h r2=%h rd=%h ctrl=%h, required alu=%h zero=%b hilo=%h pcsum=%h pc4=%h r1=%h r2=%h rd=%h ctrl=%h",
                                 txn, e.op, act.alu, act.zero, act.hilo, act.pcsum, act.pc4, act.r1, act.r2, act.rd, act.ctrl,
                                 e.alu, e.zero, e.hilo, e.pcsum, e.pc4, e.r1, e.r2, e.rd, e.ctrl);
                    end else begin
                        $display("txn %0d op=%0d alu=%h hilo=%h ok", txn, e.op, act.alu, act.hilo);
                    end
                end
            end else begin
                checks++;
                if (bus.oCtrl != 0) begin
                    failures++;
                    $display("FAIL bubble_ctrl: got oCtrl=%h with oValid=0, required 0", bus.oCtrl);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [3:0] op;
        Reset = 1'b1;
        bus.iValid = 1'b1; bus.iOp = OP_MULT; bus.iReadReg1 = 32'd3; bus.iReadReg2 = 32'd5;
        bus.iImm = 32'd1; bus.iPCPlus4 = 32'h40; bus.iRegDst = 5'd3; bus.iCtrl = 16'hBEEF; bus.iFlush = 1'b0;
        repeat (2) @(posedge Clk);
        #1;
        check_quiet("reset_state");
        bus.iValid = 1'b0;
        @(negedge Clk); #2;
        Reset = 1'b0;
        @(posedge Clk); #1;

        // Directed cases
        send(OP_ADD, 32'd5, 32'd7, 32'd0, 32'h200, 5'd1, 16'h0011);
        send(OP_SUB, 32'd9, 32'd9, 32'd4, 32'h100, 5'd2, 16'h0022);
        send(OP_MULT, 32'hFFFF_FFFD, 32'd4, 32'd8, 32'h300, 5'd3, 16'h0033);
        send(OP_DIVU, 32'd100, 32'd7, 32'd0, 32'h304, 5'd4, 16'h0044);
        send(OP_DIV, 32'd7, 32'd0, 32'd0, 32'h308, 5'd5, 16'h0055);
        send(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h30C, 5'd6, 16'h0066);
        send(OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'd0, 32'h310, 5'd7, 16'h0077);
        send(OP_SRA, 32'h8000_0010, 32'hFFFF_FFE4, 32'd0, 32'h314, 5'd8, 16'h0088);
        send(OP_SLT, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'h318, 5'd9, 16'h0099);
        send(OP_SLTU, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'h31C, 5'd10, 16'h00AA);

        // Flush at the 10th BUSY cycle (acceptance cycle plus ten BUSY cycles of stall)
        bus.iValid = 1'b1; bus.iOp = OP_MULTU; bus.iReadReg1 = 32'd1234; bus.iReadReg2 = 32'd5678;
        n = 0;
        for (int i = 0; i < 60 && n < 11; i++) begin
            @(negedge Clk);
            if (bus.oStall) n++;
        end
        checks++;
        if (n != 11) begin
            failures++;
            $display("FAIL flush_reach: got %0d stall cycles, required 11", n);
        end
        bus.iFlush = 1'b1;
        #1;
        checks++;
        if (bus.oStall) begin
            failures++;
            $display("FAIL flush_stall: got oStall=1 during flush, required 0");
        end
        @(posedge Clk); #1;
        bus.iFlush = 1'b0;
        bus.iValid = 1'b0;
        checks++;
        if (bus.oValid) begin
            failures++;
            $display("FAIL flush_bubble: got oValid=1 after flush edge, required 0");
        end
        send(OP_XOR, 32'h0F0F_0F0F, 32'h00FF_00FF, 32'd2, 32'h400, 5'd11, 16'h00BB);
        idle(40);

        // Asynchronous reset clears a live result between edges
        send(OP_OR, 32'h1234_0000, 32'h0000_5678, 32'd3, 32'h500, 5'd12, 16'h00CC);
        @(negedge Clk); #2;
        Reset = 1'b1;
        #1;
        check_quiet("reset_clears_outputs");
        @(posedge Clk); #4;
        Reset = 1'b0;
        @(posedge Clk); #1;

        // Reset in the middle of a multiply: nothing may ever be emitted for it
        bus.iValid = 1'b1; bus.iOp = OP_MULT; bus.iReadReg1 = 32'd77; bus.iReadReg2 = 32'd99;
        repeat (6) @(negedge Clk);
        checks++;
        if (!bus.oStall) begin
            failures++;
            $display("FAIL busy_stall: got oStall=0 mid-multiply, required 1");
        end
        #2;
        Reset = 1'b1;
        #1;
        check_quiet("reset_mid_busy");
        bus.iValid = 1'b0;
        @(negedge Clk); #2;
        Reset = 1'b0;
        @(posedge Clk); #1;
        idle(40);
        send(OP_ADD, 32'd1, 32'd1, 32'd0, 32'h600, 5'd13, 16'h00DD);

        // Randomised traffic
        for (int t = 0; t < 120; t++) begin
            if ($urandom_range(0, 9) == 0) idle($urandom_range(1, 3));
            op = 4'($urandom_range(0, 14));
            if (op >= 4'd11 && $urandom_range(0, 1) == 1) op = 4'($urandom_range(0, 10));
            send(op, rand_word(), rand_word(), $urandom, $urandom, 5'($urandom), 16'($urandom));
        end

        idle(5);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: got %0d outstanding results, required 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
